// File: rtl/mcu_spi_target.sv
// mcu_spi_target: FPGA-side SPI target (mode 0) for the MCU link.
// The SPI pins are oversampled in the clk domain. Received bytes are presented
// as rx_data/rx_strobe/rx_start. The decoder's reply byte, captured one clk after
// each strobe, is shifted back out on MISO during the next byte.
module mcu_spi_target #(
  parameter int SYNC_STAGES = 2  // synchroniser depth, must be >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csn,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_start,
  input  logic [7:0] tx_data
);

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_ACTIVE    = 2'd2;

  // Bundled pin order within each synchroniser stage.
  localparam int PIN_MOSI = 0;
  localparam int PIN_SCK  = 1;
  localparam int PIN_CSN  = 2;

  // All three pins share one delay line so CSN and MOSI stay aligned with SCK.
  // Stages clear to 0 on reset, so a CSN that is really high must propagate
  // through the whole chain before WAIT_IDLE is left.
  logic [SYNC_STAGES-1:0][2:0] sync_reg;

  logic csn_s;
  logic sck_s;
  logic mosi_s;
  logic sck_prev_reg;
  logic sck_rise;
  logic sck_fall;

  logic [1:0] state_reg,     state_next;
  logic [2:0] bit_cnt_reg,   bit_cnt_next;
  logic [7:0] rx_shift_reg,  rx_shift_next;
  logic [7:0] tx_shift_reg,  tx_shift_next;
  logic       first_reg,     first_next;
  logic [7:0] rx_data_reg,   rx_data_next;
  logic       rx_strobe_reg, rx_strobe_next;
  logic       rx_start_reg,  rx_start_next;
  logic       tx_load_reg,   tx_load_next;

  // Shift the raw pin samples through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], {spi_csn, spi_sck, spi_mosi}};
    end
  end

  assign csn_s  = sync_reg[SYNC_STAGES-1][PIN_CSN];
  assign sck_s  = sync_reg[SYNC_STAGES-1][PIN_SCK];
  assign mosi_s = sync_reg[SYNC_STAGES-1][PIN_MOSI];

  // Remember the previous synchronised SCK level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_prev_reg <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
    end
  end

  assign sck_rise = sck_s & ~sck_prev_reg;
  assign sck_fall = ~sck_s & sck_prev_reg;

  // Frame state machine, receive shifter and reply shifter.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    first_next     = first_reg;
    rx_data_next   = rx_data_reg;
    rx_strobe_next = 1'b0;
    rx_start_next  = 1'b0;
    // The decoder registers its reply on the strobe cycle, so the reply is
    // picked up one clk after the strobe.
    tx_load_next   = rx_strobe_reg;

    case (state_reg)
      ST_WAIT_IDLE: begin
        // A frame already running when reset released is ignored entirely.
        if (csn_s) begin
          state_next = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!csn_s) begin
          state_next    = ST_ACTIVE;
          bit_cnt_next  = 3'd0;
          first_next    = 1'b1;
          tx_shift_next = 8'h00;
          // A reply belonging to the previous frame must not leak into the
          // first byte of this one.
          tx_load_next  = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (csn_s) begin
          // Deselect wins over a coinciding 8th edge; partial bytes vanish.
          state_next   = ST_IDLE;
          bit_cnt_next = 3'd0;
        end else begin
          if (tx_load_reg) begin
            tx_shift_next = tx_data;
          end
          if (sck_rise) begin
            rx_shift_next = {rx_shift_reg[6:0], mosi_s};
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next   = {rx_shift_reg[6:0], mosi_s};
              rx_strobe_next = 1'b1;
              rx_start_next  = first_reg;
              first_next     = 1'b0;
            end
          end else if (sck_fall && (bit_cnt_reg != 3'd0)) begin
            // Falling edges between bytes are skipped so a freshly loaded
            // reply keeps its MSB on the line for the next first rise.
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
          end
        end
      end

      default: begin
        state_next = ST_WAIT_IDLE;
      end
    endcase
  end

  // Register the frame state; reset also cancels any pending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_WAIT_IDLE;
      bit_cnt_reg   <= 3'd0;
      rx_shift_reg  <= 8'h00;
      tx_shift_reg  <= 8'h00;
      first_reg     <= 1'b0;
      rx_data_reg   <= 8'h00;
      rx_strobe_reg <= 1'b0;
      rx_start_reg  <= 1'b0;
      tx_load_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      first_reg     <= first_next;
      rx_data_reg   <= rx_data_next;
      rx_strobe_reg <= rx_strobe_next;
      rx_start_reg  <= rx_start_next;
      tx_load_reg   <= tx_load_next;
    end
  end

  assign rx_data   = rx_data_reg;
  assign rx_strobe = rx_strobe_reg;
  assign rx_start  = rx_start_reg;
  // MISO is driven only while selected; it reads 0 in every other state.
  assign spi_miso  = (state_reg == ST_ACTIVE) & tx_shift_reg[7];

endmodule

// File: tb/tb_mcu_spi_target.sv
// tb_mcu_spi_target: directed bench for mcu_spi_target. An MCU model drives
// mode-0 frames asynchronously to clk; a decoder model replies with
// rx_data ^ key on every strobe; a monitor collects received bytes.
module tb_mcu_spi_target;

  localparam int SYNC    = 2;
  localparam int PH_MIN  = SYNC + 3;
  localparam int GAP_MIN = SYNC + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_csn = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic       rx_start;
  logic [7:0] tx_data;

  int         n_vec = 0;
  int         n_err = 0;
  int         proto_err = 0;
  logic [7:0] key = 8'h00;
  logic       strobe_prev = 1'b0;
  logic [8:0] rxq[$];
  logic [7:0] fb[8];
  logic [7:0] miso_got[8];

  always #5 clk = ~clk;

  mcu_spi_target #(.SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .reset    (reset),
    .spi_csn  (spi_csn),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .rx_start (rx_start),
    .tx_data  (tx_data)
  );

  // Decoder model: registers its reply on the strobe cycle.
  always @(posedge clk) begin
    if (reset) tx_data <= 8'h00;
    else if (rx_strobe) tx_data <= rx_data ^ key;
  end

  // Collect strobed bytes and watch strobe/start pulse rules.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_strobe && strobe_prev) proto_err++;
      if (rx_start && !rx_strobe) proto_err++;
      if (rx_strobe) rxq.push_back({rx_start, rx_data});
    end
    strobe_prev = rx_strobe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // One SCK period, mode 0: MOSI set while low, MISO sampled at the rise.
  task automatic sck_bit(input logic b, input int ph, output logic m);
    spi_mosi = b;
    #(ph * 10);
    spi_sck = 1'b1;
    m = spi_miso;
    #(ph * 10);
    spi_sck = 1'b0;
  endtask

  // Send fb[0..n-1]; byte cut_byte is truncated to cut_bits bits.
  task automatic frame(input int n, input int cut_byte, input int cut_bits,
                       input int ph, input int gap);
    logic [7:0] r;
    logic       m;
    int         lim;
    int         off;
    @(negedge clk);
    off = $urandom_range(1, 8);
    if (off >= 5) off++;
    #(off);
    spi_csn = 1'b0;
    for (int k = 0; k < n; k++) begin
      r = 8'h00;
      lim = (k == cut_byte) ? cut_bits : 8;
      for (int i = 0; i < lim; i++) begin
        sck_bit(fb[k][7-i], ph, m);
        r = {r[6:0], m};
      end
      miso_got[k] = r;
      if (k == cut_byte) break;
    end
    #(ph * 10);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    #(gap * 10);
  endtask

  task automatic check_rx(input string tag, input int nexp);
    int got_n;
    got_n = rxq.size();
    chk($sformatf("%s_count", tag), got_n, nexp);
    for (int i = 0; i < nexp && i < got_n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), rxq[i][7:0], fb[i]);
      chk($sformatf("%s_start%0d", tag, i), rxq[i][8], (i == 0) ? 1 : 0);
    end
    rxq.delete();
  endtask

  task automatic check_miso(input string tag, input int n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_miso%0d", tag, k), miso_got[k],
          (k == 0) ? 8'h00 : (fb[k-1] ^ key));
  endtask

  initial begin
    logic m;
    // T1: reset values, then IDLE reached SYNC+1 clk after release.
    repeat (4) @(negedge clk);
    chk("t1_rx_data", rx_data, 8'h00);
    chk("t1_rx_strobe", rx_strobe, 0);
    chk("t1_rx_start", rx_start, 0);
    chk("t1_miso", spi_miso, 0);
    reset = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    @(negedge clk);
    chk("t1_idle", dut.state_reg, 2'd1);
    rxq.delete();

    // T2: 0x00, 0xAA, 0x55 with relaxed timing.
    key = 8'h00;
    fb[0] = 8'h00; fb[1] = 8'hAA; fb[2] = 8'h55;
    frame(3, -1, 0, 6, 6);
    check_rx("t2", 3);
    check_miso("t2", 3);

    // T3: decoder echoes; MCU reads 0x00, 0x5C, 0x42.
    fb[0] = 8'h5C; fb[1] = 8'h42; fb[2] = 8'h7E;
    frame(3, -1, 0, PH_MIN, GAP_MIN);
    check_rx("t3", 3);
    check_miso("t3", 3);

    // T4: second byte aborted after 5 bits, then a clean frame.
    fb[0] = 8'h11; fb[1] = 8'h22;
    frame(2, 1, 5, PH_MIN, GAP_MIN);
    check_rx("t4a", 1);
    chk("t4a_miso0", miso_got[0], 8'h00);
    key = 8'h0F;
    fb[0] = 8'h33; fb[1] = 8'h44; fb[2] = 8'h55;
    frame(3, -1, 0, PH_MIN, GAP_MIN);
    check_rx("t4b", 3);
    check_miso("t4b", 3);

    // T5: reset mid-byte with CSN held low; remaining bits must be ignored.
    @(negedge clk);
    #3;
    spi_csn = 1'b0;
    for (int i = 0; i < 3; i++) sck_bit(1'b1, PH_MIN, m);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_rx_strobe", rx_strobe, 0);
    chk("t5_miso", spi_miso, 0);
    reset = 1'b0;
    rxq.delete();
    for (int i = 0; i < 13; i++) begin
      sck_bit(i[0], PH_MIN, m);
      if (m !== 1'b0) proto_err++;
    end
    #(PH_MIN * 10);
    spi_csn = 1'b1;
    #(GAP_MIN * 10);
    chk("t5_no_strobe", rxq.size(), 0);
    key = 8'h00;
    fb[0] = 8'hC3; fb[1] = 8'h3C;
    frame(2, -1, 0, PH_MIN, GAP_MIN);
    check_rx("t5", 2);
    check_miso("t5", 2);

    // T6: back-to-back frames at minimum phase and gap, offsets swept.
    key = 8'hA5;
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) fb[k] = 8'(8'h3B * (f * 4 + k + 1));
      frame(4, -1, 0, PH_MIN, GAP_MIN);
      check_rx($sformatf("t6f%0d", f), 4);
      check_miso($sformatf("t6f%0d", f), 4);
    end

    chk("protocol", proto_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
